// File: rtl/serial_a_paralelo_if.sv
// ============================================================================
//  serial_a_paralelo_if
//  Serial-side input and byte-side outputs of the serial-to-parallel
//  receiver. The slave modport is the receiver; the master modport is
//  whatever drives the serial line and consumes the received bytes.
//  Optional feature macro: SP_BC_COUNT_EN (adds bc_count).
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_a_paralelo_if;
   logic       in;
   logic [7:0] out;
   logic       valid_out;
   logic       active;
`ifdef SP_BC_COUNT_EN
   logic [7:0] bc_count;

   modport master (output in, input out, input valid_out, input active, input bc_count);
   modport slave  (input in, output out, output valid_out, output active, output bc_count);
`else
   modport master (output in, input out, input valid_out, input active);
   modport slave  (input in, output out, output valid_out, output active);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_a_paralelo.sv
// ============================================================================
//  serial_a_paralelo
//  Serial-to-parallel receiver for a PCIe-style lane. Samples one bit per
//  clk32f edge (MSB first), hunts for the COM symbol to find byte alignment,
//  locks after LOCK_COUNT consecutive aligned COMs and then delivers each
//  non-COM byte with a valid flag; COM bytes are treated as idle.
//  Optional feature macro: SP_BC_COUNT_EN (saturating locked-COM counter).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module serial_a_paralelo #(
   parameter logic [7:0] COM_SYMBOL = 8'hBC,
   parameter int         LOCK_COUNT = 4      // legal range 1..7
) (
   input wire logic           clk32f,
   input wire logic           reset,         // asynchronous, active low
   serial_a_paralelo_if.slave bus
);

   localparam logic [1:0] ST_UNLOCKED = 2'd0;
   localparam logic [1:0] ST_ALIGN    = 2'd1;
   localparam logic [1:0] ST_LOCKED   = 2'd2;

   localparam logic [2:0] LOCK_TARGET = 3'(LOCK_COUNT);

   logic [1:0] state_q,  state_d;
   logic [7:0] sr_q,     sr_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic [2:0] comcnt_q, comcnt_d;
   logic [7:0] out_q,    out_d;
   logic       valid_q,  valid_d;
   logic       active_q, active_d;
`ifdef SP_BC_COUNT_EN
   logic [7:0] bc_q,     bc_d;
`endif

   // Byte completed by the current edge and the two qualifiers built on it.
   logic [7:0] win;
   logic       is_com;
   logic       boundary;

   assign win      = {sr_q[6:0], bus.in};
   assign is_com   = (win == COM_SYMBOL);
   assign boundary = (bitcnt_q == 3'd7);
   assign sr_d     = win;

   // State register: every flop of the receiver, cleared asynchronously.
   always_ff @(posedge clk32f or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_UNLOCKED;
         sr_q     <= 8'h00;
         bitcnt_q <= 3'd0;
         comcnt_q <= 3'd0;
         out_q    <= 8'h00;
         valid_q  <= 1'b0;
         active_q <= 1'b0;
`ifdef SP_BC_COUNT_EN
         bc_q     <= 8'h00;
`endif
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         bitcnt_q <= bitcnt_d;
         comcnt_q <= comcnt_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         active_q <= active_d;
`ifdef SP_BC_COUNT_EN
         bc_q     <= bc_d;
`endif
      end
   end

   // Next state: hunt for COM at any bit offset, then confirm it on byte boundaries.
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q + 3'd1;
      comcnt_d = comcnt_q;
      case (state_q)
         ST_UNLOCKED: begin
            // bitcnt is parked at 0 so the first slot after a match starts cleanly.
            bitcnt_d = 3'd0;
            if (is_com) begin
               comcnt_d = 3'd1;
               state_d  = (LOCK_COUNT == 1) ? ST_LOCKED : ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            if (boundary) begin
               if (is_com) begin
                  comcnt_d = comcnt_q + 3'd1;
                  if ((comcnt_q + 3'd1) == LOCK_TARGET) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  comcnt_d = 3'd0;
                  state_d  = ST_UNLOCKED;
               end
            end
         end
         ST_LOCKED: begin
            // Lock is only lost through reset.
            state_d = ST_LOCKED;
         end
         default: begin
            bitcnt_d = 3'd0;
            comcnt_d = 3'd0;
            state_d  = ST_UNLOCKED;
         end
      endcase
   end

   // Outputs: byte delivery and idle handling on locked byte boundaries only.
   always_comb begin
      out_d    = out_q;
      valid_d  = valid_q;
      active_d = (state_d == ST_LOCKED);
`ifdef SP_BC_COUNT_EN
      bc_d     = bc_q;
`endif
      if ((state_q == ST_LOCKED) && boundary) begin
         if (!is_com) begin
            out_d   = win;
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
`ifdef SP_BC_COUNT_EN
            if (bc_q != 8'hFF) begin
               bc_d = bc_q + 8'd1;
            end
`endif
         end
      end
   end

   assign bus.out       = out_q;
   assign bus.valid_out = valid_q;
   assign bus.active    = active_q;
`ifdef SP_BC_COUNT_EN
   assign bus.bc_count  = bc_q;
`endif

endmodule

`default_nettype wire

// File: doc/serial_a_paralelo.md
# serial_a_paralelo

Serial-to-parallel receiver for the PCIe physical-layer lane; the far end of `paralelo_a_serial`. It samples one bit per `clk32f` cycle, MSB first, and hunts for the COM symbol (0xBC) to find byte alignment. After `LOCK_COUNT` consecutive aligned COM symbols it declares lock. It then delivers each non-COM byte to the byte-side logic with a valid flag, and treats COM bytes as idle.

## Interface
Parameters:
- `COM_SYMBOL`, default 8'hBC: idle/alignment symbol.
- `LOCK_COUNT`, default 4: consecutive aligned COM symbols required to lock; legal range 1..7.

Ports:
- `clk32f`, input, 1: bit clock. The only clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `in`, input, 1: serial data, MSB of each byte first.
- `out`, output, 8: last received data byte.
- `valid_out`, output, 1: `out` holds a data (non-COM) byte in the current byte slot.
- `active`, output, 1: receiver is locked.
- `bc_count`, output, 8: only present with `SP_BC_COUNT_EN`.

## Operation
- **Shift register:** `sr[7:0]`. On every edge, `sr <= {sr[6:0], in}`. The comparison window `win = {sr[6:0], in}`, which is the byte completed by the current edge.
- **Bit counter:** `bitcnt[2:0]`. Meaningful only in ALIGN and LOCKED. A boundary edge is one where `bitcnt == 7`; `bitcnt` then wraps to 0.
- **FSM states:** UNLOCKED, ALIGN, LOCKED.
  - UNLOCKED: compare `win` to `COM_SYMBOL` on every edge.
    - On a match: go to ALIGN, set `comcnt <= 1` and `bitcnt <= 0`.
    - If `LOCK_COUNT == 1`: go straight to LOCKED instead.
  - ALIGN: `bitcnt` increments every edge. Compare only on boundary edges.
    - If `win == COM_SYMBOL`: `comcnt++`. When it reaches `LOCK_COUNT`, go to LOCKED and set `active <= 1`.
    - If `win != COM_SYMBOL`: go to UNLOCKED and clear `comcnt`.
    - COM patterns at non-boundary offsets are ignored.
  - LOCKED: `bitcnt` increments every edge. On each boundary edge:
    - If `win != COM_SYMBOL`: `out <= win`, `valid_out <= 1`.
    - If `win == COM_SYMBOL`: `valid_out <= 0`, `out` holds its previous value.
    - LOCKED is left only via reset. There is no loss-of-lock detection.
- `out` and `valid_out` change only on LOCKED boundary edges. They are therefore stable for 8 `clk32f` cycles, so a `clk4f` byte-rate consumer can sample them.
- The first byte slot after lock begins on the edge following the locking edge.

## Timing
- **Reset (asserted low, asynchronous):**
  - `sr = 0`, `bitcnt = 0`, `comcnt = 0`, state UNLOCKED.
  - `out = 8'h00`, `valid_out = 0`, `active = 0`, `bc_count = 0`.
  - Because `sr` resets to 0, a false COM match right after reset is impossible.
- **Reset mid-byte or mid-lock:** everything clears immediately. Alignment must be reacquired from scratch.
- **Latency:** `out`/`valid_out` update on the same edge that samples the byte's LSB. They are visible one cycle after that LSB is presented.
- **Lock time:** the edge completing the first COM, plus `8*(LOCK_COUNT-1)` edges. `active` rises on the edge completing the `LOCK_COUNT`-th aligned COM. That COM itself is not delivered and does not assert `valid_out`.
- **ALIGN failure:** on a non-COM boundary byte the FSM returns to UNLOCKED on that edge. The hunt resumes on the next edge and may rematch within the following 7 bits.
- **Simultaneous events:** reset dominates all other events.

## Configuration
- **`SP_BC_COUNT_EN` defined:**
  - Adds output `bc_count[7:0]`.
  - It increments on every LOCKED boundary edge where `win == COM_SYMBOL`, and saturates at 255.
  - It is cleared only by reset.
  - COM symbols seen during UNLOCKED/ALIGN are not counted.
- **`SP_BC_COUNT_EN` undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
- **Reset values:** hold `reset = 0` for 3 cycles with random `in` -> `out = 00`, `valid_out = 0`, `active = 0` throughout.
- **Lock:** drive 3 random bits, then 0xBC x4, then 0x5A -> `active` rises on the edge completing the 4th BC. 8 edges later `out = 5A` and `valid_out = 1`.
- **Data and idle:** after lock, send 0x01, 0xBC, 0xFF -> `out` = 01 (valid 1), then 01 (valid 0), then FF (valid 1). Each value holds for 8 cycles.
- **Broken alignment:** send 0xBC, 0xBC, 0x3C, then 0xBC x4 -> no lock after the 3C. Lock only after the final 4th BC.
- **Mid-lock reset:** assert reset for 1 cycle while locked during byte 0x77 -> outputs return to reset values immediately. `active` stays 0 until 4 new aligned BCs.
- **`SP_BC_COUNT_EN`:** locked, send 300 BC bytes -> `bc_count` saturates at 255. Also check with the macro off: the testbench still compiles without the port.
